// File: rtl/driver_punte_h.sv
// One-channel H-bridge driver: direction FSM with coast dead-time on reversal and a
// duty ramp applied only at PWM period boundaries, driving L298N-style in1/in2/en.
module driver_punte_h #(
    parameter int unsigned PWM_BITS    = 12,
    parameter int unsigned DEAD_CYCLES = 50,
    parameter int unsigned RAMP_STEP   = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          directie,
    input  logic [PWM_BITS-1:0] factor_dc,
    output logic                in1,
    output logic                in2,
    output logic                en,
    output logic [PWM_BITS-1:0] duty_aplicat,
    output logic                timp_mort
);
    localparam int unsigned DW = $clog2(DEAD_CYCLES + 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP);
    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    state_t                state, state_d;
    logic [1:0]            dir_q;
    logic [PWM_BITS-1:0]   duty_q;
    logic [PWM_BITS-1:0]   cnt, cnt_d;
    logic [DW-1:0]         dead_cnt, dead_d;
    logic                  pend_rev, pend_d;
    logic [PWM_BITS-1:0]   duty_d, ramp_val;
    logic                  is_fwd, is_rev, boundary, run_d;

    assign is_fwd   = (dir_q == DIR_FWD);
    assign is_rev   = (dir_q == DIR_REV);
    assign boundary = &cnt;
    assign cnt_d    = cnt + PWM_BITS'(1);

    // Next applied duty: step toward the target, never overshooting or wrapping
    always_comb begin
        ramp_val = duty_q;
        if (RAMP_STEP != 0) begin
            if (duty_q > duty_aplicat) begin
                if (32'(duty_q - duty_aplicat) > RAMP_STEP) begin
                    ramp_val = duty_aplicat + STEP;
                end
            end else if (32'(duty_aplicat - duty_q) > RAMP_STEP) begin
                ramp_val = duty_aplicat - STEP;
            end
        end
    end

    // Next-state and next-duty decisions, all from the registered inputs
    always_comb begin
        state_d = state;
        pend_d  = pend_rev;
        dead_d  = dead_cnt;
        duty_d  = duty_aplicat;
        case (state)
            ST_STOP: begin
                duty_d = '0;
                if (is_fwd) begin
                    state_d = ST_FWD;
                end else if (is_rev) begin
                    state_d = ST_REV;
                end
            end
            ST_FWD: begin
                if (is_rev) begin
                    state_d = ST_DEAD;
                    pend_d  = 1'b1;
                    dead_d  = DEAD_LOAD;
                    duty_d  = '0;
                end else if (!is_fwd) begin
                    state_d = ST_STOP;
                    duty_d  = '0;
                end else if (boundary) begin
                    duty_d = ramp_val;
                end
            end
            ST_REV: begin
                if (is_fwd) begin
                    state_d = ST_DEAD;
                    pend_d  = 1'b0;
                    dead_d  = DEAD_LOAD;
                    duty_d  = '0;
                end else if (!is_rev) begin
                    state_d = ST_STOP;
                    duty_d  = '0;
                end else if (boundary) begin
                    duty_d = ramp_val;
                end
            end
            ST_DEAD: begin
                duty_d = '0;
                if (!is_fwd && !is_rev) begin
                    state_d = ST_STOP;
                    dead_d  = '0;
                end else if (is_rev != pend_rev) begin
                    // Any direction request other than the pending one restarts the coast
                    pend_d = is_rev;
                    dead_d = DEAD_LOAD;
                end else if (dead_cnt <= DW'(1)) begin
                    state_d = pend_rev ? ST_REV : ST_FWD;
                    dead_d  = '0;
                end else begin
                    dead_d = dead_cnt - DW'(1);
                end
            end
            default: begin
                state_d = ST_STOP;
                duty_d  = '0;
            end
        endcase
    end

    assign run_d = (state_d == ST_FWD) || (state_d == ST_REV);

    // State, counters and bridge pins; pins are derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q        <= 2'b00;
            duty_q       <= '0;
            cnt          <= '0;
            state        <= ST_STOP;
            dead_cnt     <= '0;
            pend_rev     <= 1'b0;
            duty_aplicat <= '0;
            in1          <= 1'b0;
            in2          <= 1'b0;
            en           <= 1'b0;
            timp_mort    <= 1'b0;
        end else begin
            dir_q        <= directie;
            duty_q       <= factor_dc;
            cnt          <= cnt_d;
            state        <= state_d;
            dead_cnt     <= dead_d;
            pend_rev     <= pend_d;
            duty_aplicat <= duty_d;
            in1          <= (state_d == ST_FWD);
            in2          <= (state_d == ST_REV);
            en           <= run_d && (cnt_d < duty_d);
            timp_mort    <= (state_d == ST_DEAD);
        end
    end
endmodule

// File: doc/driver_punte_h.md
Name: driver_punte_h

Overview:
- Consumer end of the motion-logic motor command interface.
- Takes one motor channel's 2-bit direction code and 12-bit duty factor.
- Drives the L298N-style H-bridge pins: in1, in2 and the PWM enable en.
- Inserts coast dead-time on reversal and ramps duty at PWM period boundaries so the bridge never sees shoot-through or step current.
- Instantiated twice at top level: driver A and driver B.

Parameters:
- PWM_BITS, 12, width of PWM counter and duty inputs; period = 2^PWM_BITS clocks.
- DEAD_CYCLES, 50, clocks of coast (in1=in2=en=0) between opposite directions; minimum 1.
- RAMP_STEP, 256, maximum change of applied duty per PWM period; 0 = no ramp (target applied directly at next boundary).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- directie  input  2  direction code: 2'b10 forward, 2'b01 reverse, 2'b00 stop, 2'b11 stop
- factor_dc  input  PWM_BITS  target duty (en high for factor_dc clocks per period)
- in1  output  1  bridge input 1
- in2  output  1  bridge input 2
- en  output  1  bridge PWM enable
- duty_aplicat  output  PWM_BITS  currently applied duty
- timp_mort  output  1  high while in DEAD state

Behaviour:
- Reset (async, rst_n=0): state=STOP, cnt=0, duty_aplicat=0, in1=in2=en=0, timp_mort=0, input registers cleared to stop. Same values forced at any time rst_n falls, including mid-DEAD or mid-period.
- Input sampling: directie and factor_dc registered once (dir_q, duty_q). All decisions use the registered copies.
- PWM counter cnt: free-running 0..2^PWM_BITS-1, wraps to 0. Boundary = cycle where cnt == 2^PWM_BITS-1. Runs in every state.
- Decode: forward/reverse = dir_q 10/01; stop = 00 or 11.
- States:
  - STOP: in1=in2=0, duty_aplicat=0.
    - dir_q forward → RUN_FWD; reverse → RUN_REV (no dead time from STOP).
  - RUN_FWD: in1=1, in2=0.
    - stop → STOP; reverse → DEAD (pending=REV, dead counter loaded DEAD_CYCLES).
  - RUN_REV: in1=0, in2=1. Symmetric to RUN_FWD.
  - DEAD: in1=in2=en=0, timp_mort=1, duty_aplicat forced 0. Dead counter decrements each clock; state exits when it reaches 0.
    - Exit to RUN of the pending direction.
    - If dir_q changes to the opposite pending direction while in DEAD: pending updated, counter reloaded.
    - If dir_q goes to stop: → STOP immediately.
    - If dir_q equals the direction last run: pending updated to it and counter reloaded; dead time is always completed.
- Outputs registered: in1/in2/en/timp_mort reflect the new state on the 2nd rising edge after directie changes (1 input-register edge + 1 state edge).
- Duty ramp (RUN states only): duty_aplicat updates only at boundaries, so there is no mid-period glitch.
  - Next = duty_q if |duty_q − duty_aplicat| ≤ RAMP_STEP (or RAMP_STEP=0); else duty_aplicat ± RAMP_STEP toward duty_q.
  - Arithmetic saturates within 0..2^PWM_BITS-1, with no wrap.
  - Entering RUN starts from duty_aplicat=0.
- en (registered) = RUN state && (cnt < duty_aplicat). Consequences:
  - duty 0 → en constantly 0.
  - max duty 4095 → en low 1 clock per period.
  - en is 0 throughout STOP and DEAD.
- Simultaneous events:
  - Direction change and boundary in the same cycle: the state transition wins and duty_aplicat is cleared.
  - factor_dc changes mid-period: no effect until the next boundary.

Test Plan:
- Reset: rst_n=0 with directie=10, factor_dc=4095 → in1=in2=en=0, duty_aplicat=0. Release: 2 edges later in1=1, in2=0.
- Ramp (RAMP_STEP=256): directie=10, factor_dc=1000 from STOP → duty_aplicat 0,256,512,768,1000 at successive boundaries, then holds. en high exactly 1000 clocks per 4096-clock period once settled.
- Reversal: running forward at duty 1000, directie→01 → 2 edges later in1=in2=en=0, timp_mort=1 for exactly 50 clocks. Then in1=0, in2=1, and the ramp restarts from 0.
- Dead-time abort/reload: during DEAD after 20 clocks, directie→00 → STOP, timp_mort=0 next edge. Repeat with directie→10 at clock 20 → counter reloads and DEAD lasts 50 further clocks.
- Stop codes: directie=11 while in RUN_REV → STOP, in1=in2=en=0, duty_aplicat=0 (same result as 00).
- Async reset mid-DEAD and mid-period (cnt=2000): outputs zero immediately without waiting for clk; after release the PWM counter restarts from 0.
